// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the MEM-stage memory access controller:
// FSM state encoding, default bus widths and the data pattern returned
// to the pipeline when a load times out.
package mem_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    // Load data substituted when the memory never acknowledges.
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // Controller states. The encoding is kept as plain constants so that
    // it can be matched against older waveform and debug scripts.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

endpackage : mem_ctrl_pkg

// File: rtl/mem_access_ctrl_sat_counter.sv
// sat_counter
// Up-counter that stops at its all-ones value instead of wrapping.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high clear
//   en    - count enable (one increment per enabled cycle)
//   count - current value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment when enabled unless already saturated.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences loads and stores of the MEM stage against a variable-latency
// memory using a req/ack handshake. While an access is outstanding the
// front of the pipeline is stalled and a bubble is pushed into MEM_WB.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   memRead_in, memWrite_in    - EX/MEM load / store request
//   addr_in, wdata_in          - EX/MEM address and store data
//   mem_req, mem_we            - registered request and write strobe
//   mem_addr, mem_wdata        - registered address and write data
//   mem_ack, mem_rdata         - completion pulse and read data
//   stall, wb_bubble           - pipeline hold / MEM_WB bubble
//   readData_out               - captured load data to MEM_WB
//   err_timeout                - sticky memory timeout flag
//   stall_cycles               - saturating count of stalled cycles
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_bubble,
    output logic [DATA_W-1:0] readData_out,
    output logic              err_timeout,
    output logic [15:0]       stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,  state_d;
    logic              req_q,    req_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              err_q,    err_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // Hold the pipeline from the cycle a memory op is first seen until the
    // access resolves. DONE is deliberately stall-free so the completing
    // instruction leaves EX/MEM exactly once.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            stall = 1'b0;
        end else if ((state_q == ST_IDLE) && (memRead_in || memWrite_in)) begin
            stall = 1'b1;
        end else if (state_q == ST_ACCESS) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    assign wb_bubble = stall;

    // Access sequencing: issue, wait for ack or timeout, then one release cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (memRead_in || memWrite_in) begin
                    state_d = ST_ACCESS;
                    req_d   = 1'b1;
                    // A simultaneous read+write request is issued as a store.
                    we_d    = memWrite_in;
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: release the pipeline with a recognisable value.
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = DATA_W'(TIMEOUT_DATA);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                // Inputs still show the completing op here; do not resample.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Controller state and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            err_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall),
        .count (stall_cycles)
    );

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign readData_out = rdata_q;
    assign err_timeout  = err_q;

endmodule : mem_access_ctrl
